// File: rtl/im_arb_pkg.sv
// Shared constants and helpers for the instruction-memory fetch arbiter.
package im_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 16;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Requester index; also the tag carried with each in-flight read.
  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Outstanding responses a port still owns after this edge.
  // pop is only ever set while count is non-zero, so no underflow.
  function automatic logic [2:0] credit(input logic [1:0] count,
                                        input logic       inflight,
                                        input logic       pop);
    return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/im_fetch_arb_if.sv
// Requester handshakes plus the instruction-memory port of im_fetch_arb.
interface im_fetch_arb_if #(
  parameter int unsigned ADDR_W = im_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = im_arb_pkg::DATA_W_DEF
) ();

  logic              f_req_valid;
  logic              f_req_ready;
  logic [ADDR_W-1:0] f_req_addr;
  logic              f_flush;
  logic              f_rsp_valid;
  logic              f_rsp_ready;
  logic [DATA_W-1:0] f_rsp_instr;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_rsp_valid;
  logic              d_rsp_ready;
  logic [DATA_W-1:0] d_rsp_instr;

  logic [ADDR_W-1:0] im_addr;
  logic              im_rd_en;
  logic [DATA_W-1:0] im_instr;

  // Arbiter side.
  modport slave (
    input  f_req_valid, f_req_addr, f_flush, f_rsp_ready,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    input  im_instr,
    output f_req_ready, f_rsp_valid, f_rsp_instr,
    output d_req_ready, d_rsp_valid, d_rsp_instr,
    output im_addr, im_rd_en
  );

  // Requester / memory side.
  modport master (
    output f_req_valid, f_req_addr, f_flush, f_rsp_ready,
    output d_req_valid, d_req_addr, d_rsp_ready,
    output im_instr,
    input  f_req_ready, f_rsp_valid, f_rsp_instr,
    input  d_req_ready, d_rsp_valid, d_rsp_instr,
    input  im_addr, im_rd_en
  );

endinterface

// File: rtl/im_rsp_fifo.sv
// Two-entry first-word-fall-through response FIFO with synchronous clear.
module im_rsp_fifo #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_pop;

  // Pointer/count update; a clear discards everything, including a same-edge push.
  always_comb begin
    do_pop   = pop & (count_q != 2'd0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The upstream credit check must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && !clr) begin
      assert (!(push && !do_pop && count_q == 2'd2));
    end
  end

  assign valid = (count_q != 2'd0);
  assign data  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/im_fetch_arb.sv
// Fetch/debug arbiter and read sequencer for the single-port instruction memory.
module im_fetch_arb
  import im_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic           clk,
  input logic           rst_n,
  im_fetch_arb_if.slave bus
);

  localparam int unsigned      SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic              im_rd_en_q, im_rd_en_d;
  logic              inflight_q, inflight_d;
  port_e             tag_q, tag_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic              f_valid, d_valid;
  logic [DATA_W-1:0] f_data, d_data;
  logic [1:0]        f_count, d_count;
  logic              f_pop, d_pop;
  logic              f_push, d_push;
  logic [2:0]        f_credit, d_credit;
  logic              f_elig, d_elig;
  logic              f_want, d_want;
  logic              grant_f, grant_d;

  // Credit check and grant: fetch by default, debug when starved or fetch idle.
  always_comb begin
    f_pop    = f_valid & bus.f_rsp_ready;
    d_pop    = d_valid & bus.d_rsp_ready;
    f_credit = credit(f_count, inflight_q & (tag_q == PORT_F), f_pop);
    d_credit = credit(d_count, inflight_q & (tag_q == PORT_D), d_pop);
    f_elig   = (f_credit < 3'd2);
    d_elig   = (d_credit < 3'd2);
    f_want   = bus.f_req_valid & f_elig;
    d_want   = bus.d_req_valid & d_elig;
    grant_d  = d_want & ((starve_cnt_q == STARVE_LIM) | ~f_want);
    grant_f  = f_want & ~grant_d;
  end

  // Issue registers: launch the granted read, otherwise idle the memory.
  always_comb begin
    im_addr_d  = im_addr_q;
    im_rd_en_d = 1'b0;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    if (grant_d) begin
      im_addr_d  = bus.d_req_addr;
      im_rd_en_d = 1'b1;
      inflight_d = 1'b1;
      tag_d      = PORT_D;
    end else if (grant_f) begin
      im_addr_d  = bus.f_req_addr;
      im_rd_en_d = 1'b1;
      inflight_d = 1'b1;
      tag_d      = PORT_F;
    end
  end

  // Starvation counter: counts debug's lost cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_d || !bus.d_req_valid) begin
      starve_cnt_d = '0;
    end else if (d_elig && starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // A read is in flight for exactly one cycle and captures on the flush edge
  // itself, so the squash is applied directly to that capture.
  always_comb begin
    f_push = inflight_q & (tag_q == PORT_F) & ~bus.f_flush;
    d_push = inflight_q & (tag_q == PORT_D);
  end

  // Issue, tag and starvation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_addr_q    <= '0;
      im_rd_en_q   <= 1'b0;
      inflight_q   <= 1'b0;
      tag_q        <= PORT_F;
      starve_cnt_q <= '0;
    end else begin
      im_addr_q    <= im_addr_d;
      im_rd_en_q   <= im_rd_en_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  im_rsp_fifo #(.DATA_W(DATA_W)) u_f_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.f_flush),
    .push      (f_push),
    .push_data (bus.im_instr),
    .pop       (f_pop),
    .valid     (f_valid),
    .data      (f_data),
    .count     (f_count)
  );

  im_rsp_fifo #(.DATA_W(DATA_W)) u_d_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .push      (d_push),
    .push_data (bus.im_instr),
    .pop       (d_pop),
    .valid     (d_valid),
    .data      (d_data),
    .count     (d_count)
  );

  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;
  assign bus.f_rsp_valid = f_valid;
  assign bus.f_rsp_instr = f_data;
  assign bus.d_rsp_valid = d_valid;
  assign bus.d_rsp_instr = d_data;
  assign bus.im_addr     = im_addr_q;
  assign bus.im_rd_en    = im_rd_en_q;

endmodule

// File: tb/tb_im_fetch_arb.sv
// Scoreboard bench for im_fetch_arb: accepted requests queue expected words,
// a negedge monitor compares every delivered response.
module tb_im_fetch_arb;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_fetch_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  im_fetch_arb #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory image: byte swap of the address, xor a constant.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign bus.im_instr = mem_word(bus.im_addr);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] f_exp[$];
  logic [15:0] d_exp[$];
  int f_acc_cyc[$], f_del_cyc[$], d_acc_cyc[$], d_del_cyc[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare deliveries, apply flush, record new acceptances.
  always @(negedge clk) begin
    if (!rst_n) begin
      f_exp.delete();
      d_exp.delete();
    end else begin
      if (bus.f_rsp_valid && bus.f_rsp_ready) begin
        f_del_cyc.push_back(cyc);
        if (f_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL f_rsp_unexpected: got instr 0x%0h, expected no response", bus.f_rsp_instr);
        end else begin
          check("f_rsp_instr", 32'(bus.f_rsp_instr), 32'(f_exp.pop_front()));
        end
      end
      if (bus.d_rsp_valid && bus.d_rsp_ready) begin
        d_del_cyc.push_back(cyc);
        if (d_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL d_rsp_unexpected: got instr 0x%0h, expected no response", bus.d_rsp_instr);
        end else begin
          check("d_rsp_instr", 32'(bus.d_rsp_instr), 32'(d_exp.pop_front()));
        end
      end
      if (bus.f_flush) f_exp.delete();
      if (bus.f_req_valid && bus.f_req_ready) begin
        f_exp.push_back(mem_word(bus.f_req_addr));
        f_acc_cyc.push_back(cyc);
      end
      if (bus.d_req_valid && bus.d_req_ready) begin
        d_exp.push_back(mem_word(bus.d_req_addr));
        d_acc_cyc.push_back(cyc);
      end
    end
  end

  // Present a request until accepted; returns #1 after the accepting edge.
  task automatic issue(input bit dbg, input logic [15:0] a, output int waited);
    bit done = 1'b0;
    waited = 0;
    if (dbg) begin bus.d_req_valid = 1'b1; bus.d_req_addr = a; end
    else     begin bus.f_req_valid = 1'b1; bus.f_req_addr = a; end
    while (!done) begin
      @(negedge clk);
      if (dbg ? bus.d_req_ready : bus.f_req_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 60) begin
          checks++; errors++;
          $display("FAIL accept_timeout: addr 0x%0h not accepted after %0d cycles", a, waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    if (dbg) bus.d_req_valid = 1'b0;
    else     bus.f_req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((f_exp.size() != 0 || d_exp.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check({name, "_drain"}, 32'(f_exp.size() + d_exp.size()), 0);
  endtask

  task automatic clear_logs();
    f_acc_cyc.delete(); f_del_cyc.delete();
    d_acc_cyc.delete(); d_del_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int w, wf, wd, lost, total;
    bit seen;

    bus.f_req_valid = 1'b0; bus.f_req_addr = '0; bus.f_flush = 1'b0; bus.f_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b0; bus.d_req_addr = '0; bus.d_rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_im_rd_en",    32'(bus.im_rd_en), 0);
    check("rst_im_addr",     32'(bus.im_addr), 0);
    check("rst_f_rsp_valid", 32'(bus.f_rsp_valid), 0);
    check("rst_d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while a read is on the memory bus
    issue(1'b0, 16'h0005, w);
    check("mid_im_rd_en", 32'(bus.im_rd_en), 1);
    check("mid_im_addr",  32'(bus.im_addr), 32'h0005);
    rst_n = 1'b0;
    #1;
    check("mid_rst_im_rd_en",    32'(bus.im_rd_en), 0);
    check("mid_rst_im_addr",     32'(bus.im_addr), 0);
    check("mid_rst_f_rsp_valid", 32'(bus.f_rsp_valid), 0);
    check("mid_rst_d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.f_rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.f_rsp_valid) seen = 1'b1;
    end
    check("post_rst_no_rsp", 32'(seen), 0);
    @(posedge clk); #1;

    // Streaming fetch 0x0000..0x0007
    clear_logs();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 16'(i), w);
      total += w;
    end
    check("stream_req_ready_drops", 32'(total), 0);
    drain("stream");
    check("stream_count", 32'(f_del_cyc.size()), 8);
    if (f_del_cyc.size() == 8 && f_acc_cyc.size() == 8) begin
      check("stream_first_latency", 32'(f_del_cyc[0] - f_acc_cyc[0]), 2);
      check("stream_rate",          32'(f_del_cyc[7] - f_del_cyc[0]), 7);
    end

    // Back-pressure on fetch
    clear_logs();
    bus.f_rsp_ready = 1'b0;
    issue(1'b0, 16'h0010, w);
    issue(1'b0, 16'h0011, w);
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 16'h0012;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.f_req_ready) seen = 1'b1;
    end
    check("bp_ready_low",   32'(seen), 0);
    check("bp_accepts",     32'(f_acc_cyc.size()), 2);
    check("bp_hold_valid",  32'(bus.f_rsp_valid), 1);
    check("bp_hold_instr",  32'(bus.f_rsp_instr), 32'(mem_word(16'h0010)));
    @(posedge clk); #1;
    bus.f_rsp_ready = 1'b1;
    issue(1'b0, 16'h0012, w);
    check("bp_accept_on_pop", 32'(w), 0);
    drain("bp");
    check("bp_count", 32'(f_del_cyc.size()), 3);

    // Starvation: debug wins after STARVE_MAX lost cycles
    clear_logs();
    bus.d_rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) issue(1'b0, 16'(16'h0040 + i), wf);
      end
      begin
        issue(1'b1, 16'h1234, lost);
        check("starve_lost_cycles", 32'(lost), 4);
        check("starve_cnt_cleared", 32'(dut.starve_cnt_q), 0);
      end
    join
    drain("starve");
    check("starve_d_count", 32'(d_del_cyc.size()), 1);

    // Flush with fetch data in the FIFO and a fetch read in flight
    clear_logs();
    bus.f_rsp_ready = 1'b0;
    bus.d_rsp_ready = 1'b0;
    issue(1'b1, 16'h0300, wd);
    issue(1'b0, 16'h0020, w);
    issue(1'b0, 16'h0021, w);
    check("fl_inflight_addr", 32'(bus.im_addr), 32'h0021);
    bus.f_flush     = 1'b1;
    bus.f_req_valid = 1'b1;
    bus.f_req_addr  = 16'h0100;
    @(posedge clk); #1;
    bus.f_flush = 1'b0;
    check("fl_fifo_cleared", 32'(bus.f_rsp_valid), 0);
    check("fl_debug_kept",   32'(bus.d_rsp_valid), 1);
    issue(1'b0, 16'h0100, w);
    bus.f_rsp_ready = 1'b1;
    bus.d_rsp_ready = 1'b1;
    drain("flush");
    check("fl_f_deliveries", 32'(f_del_cyc.size()), 1);
    check("fl_d_deliveries", 32'(d_del_cyc.size()), 1);

    // Push, pop and accept on the debug port on one edge
    clear_logs();
    bus.d_rsp_ready = 1'b0;
    issue(1'b1, 16'h0600, w);
    issue(1'b1, 16'h0601, w);
    bus.d_rsp_ready = 1'b1;
    issue(1'b1, 16'h0602, w);
    check("sim_accept_immediate", 32'(w), 0);
    check("sim_head_valid", 32'(bus.d_rsp_valid), 1);
    check("sim_head_instr", 32'(bus.d_rsp_instr), 32'(mem_word(16'h0601)));
    for (int i = 3; i < 6; i++) issue(1'b1, 16'(16'h0600 + i), w);
    drain("sim");
    check("sim_d_count", 32'(d_del_cyc.size()), 6);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
